// File: rtl/gold_placement_sequencer.sv
// gold_placement_sequencer
//   Places N_OBJ game objects per new game. Each object draws a random
//   position inside its own fixed region. Optionally the candidate is checked
//   against every object already placed (Manhattan separation). A candidate
//   that keeps conflicting is committed anyway after MAX_RETRY rejected draws.
//
//   Build option: define PLACE_OVERLAP_CHECK_EN to build the separation check.
//   Without it, every draw is committed after a single CHECK cycle.
//
// Ports
//   Clk, Reset_n          clock, asynchronous active-low reset
//   start                 new-game request (accepted in IDLE/FIN only)
//   rand_in/rand_valid    random word; [15:0] -> x, [31:16] -> y
//   rand_ready            high in DRAW; a word is consumed when valid is also high
//   obj_wr_en             one-cycle pulse with obj_idx/obj_x/obj_y
//   busy/done             placement in progress / all objects committed
//   forced_cnt            forced commits this game (saturating)
module gold_placement_sequencer #(
    parameter int N_OBJ     = 8,
    parameter int MAX_RETRY = 15,
    parameter int MIN_SEP   = 40
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [31:0] rand_in,
    input  logic        rand_valid,
    output logic        rand_ready,
    output logic        obj_wr_en,
    output logic [2:0]  obj_idx,
    output logic [9:0]  obj_x,
    output logic [9:0]  obj_y,
    output logic        busy,
    output logic        done,
    output logic [3:0]  forced_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAW   = 3'd1,
        CHECK  = 3'd2,
        COMMIT = 3'd3,
        FIN    = 3'd4
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(N_OBJ - 1);

    // Region per object index, packed {xbase, xrange, ybase, yrange}.
    function automatic logic [39:0] region(input logic [2:0] i);
        logic [39:0] r;
        case (i)
            3'd0:    r = {10'd40,  10'd200, 10'd330, 10'd100};
            3'd1:    r = {10'd300, 10'd200, 10'd330, 10'd100};
            3'd2:    r = {10'd300, 10'd50,  10'd300, 10'd80};
            3'd3:    r = {10'd250, 10'd50,  10'd200, 10'd80};
            3'd4:    r = {10'd30,  10'd570, 10'd70,  10'd40};
            3'd5:    r = {10'd30,  10'd570, 10'd70,  10'd40};
            3'd6:    r = {10'd100, 10'd150, 10'd100, 10'd40};
            3'd7:    r = {10'd350, 10'd150, 10'd90,  10'd50};
            default: r = 40'd0;
        endcase
        return r;
    endfunction

    // base + floor(r * range / 2^16); the 26-bit product keeps the top ten
    // bits strictly below range, so the result stays inside the region.
    function automatic logic [9:0] scale(input logic [9:0] base, input logic [9:0] range,
                                         input logic [15:0] r);
        logic [25:0] prod;
        prod = {10'd0, r} * {16'd0, range};
        return base + prod[25:16];
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [9:0]  cand_x_q, cand_x_d;
    logic [9:0]  cand_y_q, cand_y_d;
    logic [3:0]  forced_q, forced_d;
    logic [39:0] region_s;
    logic        commit_s;

    logic        rand_ready_q, busy_q, done_q, wr_en_q;
    logic [2:0]  obj_idx_q;
    logic [9:0]  obj_x_q, obj_y_q;

`ifdef PLACE_OVERLAP_CHECK_EN
    localparam int              RW          = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]   MAX_RETRY_C = RW'(MAX_RETRY);
    localparam logic [10:0]     MIN_SEP_C   = 11'(MIN_SEP);

    logic [RW-1:0] retry_q, retry_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [9:0]    tab_x_q [N_OBJ];
    logic [9:0]    tab_y_q [N_OBJ];
    logic          conflict_s;

    function automatic logic [10:0] manhattan(input logic [9:0] ax, input logic [9:0] ay,
                                              input logic [9:0] bx, input logic [9:0] by);
        logic [9:0] dx, dy;
        dx = (ax >= bx) ? (ax - bx) : (bx - ax);
        dy = (ay >= by) ? (ay - by) : (by - ay);
        return {1'b0, dx} + {1'b0, dy};
    endfunction

    // Candidate against the committed object selected by the scan pointer.
    always_comb begin
        conflict_s = (manhattan(cand_x_q, cand_y_q, tab_x_q[ptr_q], tab_y_q[ptr_q]) < MIN_SEP_C);
    end

    // Retry counter, scan pointer and history of committed positions.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            retry_q <= '0;
            ptr_q   <= 3'd0;
            for (int i = 0; i < N_OBJ; i++) begin
                tab_x_q[i] <= 10'd0;
                tab_y_q[i] <= 10'd0;
            end
        end else begin
            retry_q <= retry_d;
            ptr_q   <= ptr_d;
            if (commit_s) begin
                tab_x_q[idx_q] <= cand_x_q;
                tab_y_q[idx_q] <= cand_y_q;
            end
        end
    end
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        forced_d = forced_q;
        commit_s = 1'b0;
        region_s = region(idx_q);
`ifdef PLACE_OVERLAP_CHECK_EN
        retry_d  = retry_q;
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    state_d  = DRAW;
                    idx_d    = 3'd0;
                    forced_d = 4'd0;
`ifdef PLACE_OVERLAP_CHECK_EN
                    retry_d  = '0;
                    ptr_d    = 3'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            DRAW: begin
                if (rand_valid) begin
                    cand_x_d = scale(region_s[39:30], region_s[29:20], rand_in[15:0]);
                    cand_y_d = scale(region_s[19:10], region_s[9:0], rand_in[31:16]);
`ifdef PLACE_OVERLAP_CHECK_EN
                    ptr_d    = 3'd0;
`endif
                    state_d  = CHECK;
                end else begin
                    state_d = DRAW;
                end
            end
            CHECK: begin
`ifdef PLACE_OVERLAP_CHECK_EN
                // The first conflict decides: redraw, or force the commit once
                // the retry budget is spent. Object 0 has nothing to compare.
                if (idx_q == 3'd0) begin
                    state_d = COMMIT;
                end else if (conflict_s) begin
                    if (retry_q < MAX_RETRY_C) begin
                        retry_d = retry_q + RW'(1);
                        state_d = DRAW;
                    end else begin
                        if (forced_q != 4'd15) begin
                            forced_d = forced_q + 4'd1;
                        end else begin
                            forced_d = forced_q;
                        end
                        state_d = COMMIT;
                    end
                end else if (ptr_q == (idx_q - 3'd1)) begin
                    state_d = COMMIT;
                end else begin
                    ptr_d   = ptr_q + 3'd1;
                    state_d = CHECK;
                end
`else
                state_d = COMMIT;
`endif
            end
            COMMIT: begin
                commit_s = 1'b1;
`ifdef PLACE_OVERLAP_CHECK_EN
                retry_d  = '0;
`endif
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = DRAW;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working registers and outputs; outputs are decoded from the next state
    // so they change on the same edge as the state they describe.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx_q        <= 3'd0;
            cand_x_q     <= 10'd0;
            cand_y_q     <= 10'd0;
            forced_q     <= 4'd0;
            rand_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            obj_idx_q    <= 3'd0;
            obj_x_q      <= 10'd0;
            obj_y_q      <= 10'd0;
        end else begin
            idx_q        <= idx_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            forced_q     <= forced_d;
            rand_ready_q <= (state_d == DRAW);
            busy_q       <= (state_d == DRAW) || (state_d == CHECK) || (state_d == COMMIT);
            done_q       <= (state_d == FIN);
            wr_en_q      <= (state_d == COMMIT);
            if (state_d == COMMIT) begin
                obj_idx_q <= idx_d;
                obj_x_q   <= cand_x_d;
                obj_y_q   <= cand_y_d;
            end
        end
    end

    assign rand_ready = rand_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign obj_wr_en  = wr_en_q;
    assign obj_idx    = obj_idx_q;
    assign obj_x      = obj_x_q;
    assign obj_y      = obj_y_q;
    assign forced_cnt = forced_q;

endmodule
